// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding {pc, instr} pairs between the fetch engine and the core.
// Flush wins over push and pop; the head reads as zero while the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // Qualify push/pop and compute next pointers and occupancy.
    always_comb begin
        do_pop   = pop_i && (count_q != '0) && !flush_i;
        do_push  = push_i && !flush_i && ((count_q != FULL) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_push && !do_pop)      count_d = count_q + (PW+1)'(1);
            else if (do_pop && !do_push) count_d = count_q - (PW+1)'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only visible through the count-gated head.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch engine in front of the core: issues req/ack fetches to instruction
// memory, buffers results in a prefetch queue, and restarts on redirects.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | no request outstanding (queue full, waiting for space)
//   REQ     | request outstanding; its data will be pushed on ack
//   DISCARD | request outstanding; its data is dropped on ack
//
// Queue space is reserved at issue: the queue only grows on a kept ack, so a
// response from REQ always fits.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [CW-1:0] q_count;
    logic [CW-1:0] count_after;
    logic [31:0]   target;
    logic [31:0]   pc_next;
    logic          push_fire, pop_fire;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    assign target     = align_pc(redirect_pc);
    assign pc_next    = fetch_pc_q + INSTR_BYTES;
    assign out_valid  = (q_count != '0);
    assign pop_fire   = out_valid && out_ready && !redirect;
    assign push_fire  = (state_q == REQ) && mem_ack && !redirect;
    assign push_entry = '{pc: fetch_pc_q, instr: mem_rdata};

    // Next-state, next fetch pc and next request address; redirect has top priority.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        mem_addr_d  = mem_addr_q;
        count_after = q_count + CW'(1) - CW'(pop_fire);
        if (redirect) begin
            fetch_pc_d = target;
            case (state_q)
                IDLE: begin
                    state_d    = REQ;
                    mem_addr_d = target;
                end
                REQ, DISCARD: begin
                    if (mem_ack) begin
                        state_d    = REQ;
                        mem_addr_d = target;
                    end else begin
                        state_d    = DISCARD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (q_count < FULL) begin
                        state_d    = REQ;
                        mem_addr_d = fetch_pc_q;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        fetch_pc_d = pc_next;
                        if (count_after < FULL) mem_addr_d = pc_next;
                        else                    state_d    = IDLE;
                    end
                end
                DISCARD: begin
                    if (mem_ack) begin
                        state_d    = REQ;
                        mem_addr_d = fetch_pc_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state, fetch pc and request address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign mem_req   = (state_q != IDLE);
    assign mem_addr  = mem_addr_q;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_fire),
        .push_data_i (push_entry),
        .pop_i       (pop_fire),
        .flush_i     (redirect),
        .head_o      (head),
        .count_o     (q_count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed phases push expected pcs,
// a monitor compares every consumed head against them.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int checks = 0;
    int errors = 0;
    int mem_lat = 0;
    int wait_cnt = 0;
    logic [31:0] exp_pc_q[$];
    logic [31:0] req_log[$];
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'h0} ^ 32'h1357_9BDF ^ a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: acks after mem_lat wait cycles, tolerates mem_req dropping.
    always @(negedge clk) begin
        mem_ack   = mem_req && !rst && (wait_cnt >= mem_lat);
        mem_rdata = mem_ack ? mem_word(mem_addr) : 32'h0;
    end

    always @(posedge clk) begin
        if (rst || !mem_req || mem_ack) wait_cnt <= 0;
        else                            wait_cnt <= wait_cnt + 1;
        if (!rst && mem_req && mem_ack) req_log.push_back(mem_addr);
    end

    // Monitor: every accepted head must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !redirect) begin
            if (exp_pc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_unexpected: got pc 0x%08h, scoreboard empty", out_pc);
            end else begin
                mon_exp = exp_pc_q.pop_front();
                check("mon_pc", out_pc, mon_exp);
                check("mon_instr", out_instr, mem_word(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat);
        cyc();
        rst = 1'b1;
        redirect = 1'b0;
        out_ready = 1'b0;
        mem_lat = lat;
        cyc();
        cyc();
        check("leftover_exp", exp_pc_q.size(), 0);
        exp_pc_q.delete();
        req_log.delete();
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while (exp_pc_q.size() != 0 && n < limit) begin
            samp();
            n++;
        end
        check({name, "_drained"}, exp_pc_q.size(), 0);
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic wait_req_addr(input logic [31:0] addr, input int limit, input string name);
        int n = 0;
        bit found = 0;
        while (!found && n < limit) begin
            samp();
            n++;
            if (mem_req && mem_addr == addr) found = 1;
        end
        check(name, 32'(found), 1);
    endtask

    task automatic check_log(input string name, input int idx, input logic [31:0] exp);
        logic [31:0] act;
        act = (idx < req_log.size()) ? req_log[idx] : 32'hDEAD_DEAD;
        check(name, act, exp);
    endtask

    initial begin
        int n;
        int hits;

        // Reset values
        repeat (2) samp();
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);

        // Zero-wait stream: 0,4,8,C on consecutive cycles
        mem_lat = 0;
        exp_pc_q.push_back(32'h0);
        exp_pc_q.push_back(32'h4);
        exp_pc_q.push_back(32'h8);
        exp_pc_q.push_back(32'hC);
        cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        n = 0;
        do begin
            samp();
            n++;
        end while (!out_valid && n < 10);
        check("p1_first_valid", 32'(out_valid), 1);
        n = 1;
        while (exp_pc_q.size() != 0 && n < 20) begin
            samp();
            n++;
        end
        check("p1_consecutive", n, 4);
        cyc();
        out_ready = 1'b0;
        check_log("p1_req0", 0, 32'h0);
        check_log("p1_req3", 3, 32'hC);

        // Backpressure with 2-wait memory: four requests then stop
        do_reset(2);
        cyc();
        rst = 1'b0;
        repeat (30) samp();
        check("p2_req_count", req_log.size(), 4);
        check_log("p2_req3", 3, 32'hC);
        check("p2_idle", 32'(mem_req), 0);
        check("p2_valid", 32'(out_valid), 1);
        check("p2_head_pc", out_pc, 32'h0);
        check("p2_head_instr", out_instr, mem_word(32'h0));
        exp_pc_q.push_back(32'h0);
        cyc();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        repeat (15) samp();
        check("p2_req_count2", req_log.size(), 5);
        check_log("p2_req4", 4, 32'h10);
        check("p2_idle2", 32'(mem_req), 0);
        exp_pc_q.push_back(32'h4);
        exp_pc_q.push_back(32'h8);
        exp_pc_q.push_back(32'hC);
        exp_pc_q.push_back(32'h10);
        cyc();
        out_ready = 1'b1;
        wait_drain("p2", 20);

        // Redirect while request to 0x8 is outstanding
        do_reset(2);
        exp_pc_q.push_back(32'h0);
        exp_pc_q.push_back(32'h4);
        exp_pc_q.push_back(32'h100);
        cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        wait_req_addr(32'h8, 40, "p3_req8_seen");
        cyc();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        cyc();
        redirect = 1'b0;
        samp();
        check("p3_discard_req", 32'(mem_req), 1);
        check("p3_discard_addr", mem_addr, 32'h8);
        check("p3_flushed", 32'(out_valid), 0);
        wait_drain("p3", 30);
        check_log("p3_req2", 2, 32'h8);
        check_log("p3_req3", 3, 32'h100);

        // Redirect coinciding with mem_ack and out_ready, two entries queued
        do_reset(2);
        cyc();
        rst = 1'b0;
        n = 0;
        while (req_log.size() != 2 && n < 30) begin
            samp();
            n++;
        end
        check("p4_two_fetched", req_log.size(), 2);
        cyc();
        cyc();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0500;
        out_ready = 1'b1;
        samp();
        check("p4_ack_coincide", 32'(mem_ack), 1);
        check("p4_head_pc", out_pc, 32'h0);
        cyc();
        redirect = 1'b0;
        out_ready = 1'b0;
        samp();
        check("p4_flushed", 32'(out_valid), 0);
        check("p4_target_req", 32'(mem_req), 1);
        check("p4_target_addr", mem_addr, 32'h500);
        exp_pc_q.push_back(32'h500);
        cyc();
        out_ready = 1'b1;
        wait_drain("p4", 30);
        check_log("p4_req3", 3, 32'h500);

        // Two redirects within one DISCARD
        do_reset(4);
        exp_pc_q.push_back(32'h300);
        cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        wait_req_addr(32'h0, 10, "p5_req0_seen");
        cyc();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        cyc();
        redirect_pc = 32'h0000_0300;
        cyc();
        redirect = 1'b0;
        samp();
        check("p5_discard_addr", mem_addr, 32'h0);
        check("p5_discard_req", 32'(mem_req), 1);
        wait_drain("p5", 40);
        check_log("p5_req0", 0, 32'h0);
        check_log("p5_req1", 1, 32'h300);
        hits = 0;
        foreach (req_log[i]) if (req_log[i] == 32'h200) hits++;
        check("p5_no_200", hits, 0);

        // Reset pulsed mid-request at 0x40
        do_reset(3);
        for (int i = 0; i < 16; i++) exp_pc_q.push_back(32'(i * 4));
        cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        wait_req_addr(32'h40, 120, "p6_req40_seen");
        rst = 1'b1;
        #1;
        check("p6_rst_req", 32'(mem_req), 0);
        check("p6_rst_valid", 32'(out_valid), 0);
        check("p6_rst_addr", mem_addr, 32'h0);
        check("p6_all_seen", exp_pc_q.size(), 0);
        exp_pc_q.delete();
        req_log.delete();
        exp_pc_q.push_back(32'h0);
        cyc();
        cyc();
        rst = 1'b0;
        n = 0;
        do begin
            samp();
            n++;
        end while (!mem_req && n < 10);
        check("p6_first_addr", mem_addr, 32'h0);
        wait_drain("p6", 20);

        // Redirect near the top of the address space: pc wraps to 0
        do_reset(0);
        exp_pc_q.push_back(32'hFFFF_FFF8);
        exp_pc_q.push_back(32'hFFFF_FFFC);
        exp_pc_q.push_back(32'h0000_0000);
        cyc();
        rst = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        out_ready = 1'b1;
        cyc();
        redirect = 1'b0;
        wait_drain("p7", 20);
        check_log("p7_req0", 0, 32'hFFFF_FFF8);
        check_log("p7_req1", 1, 32'hFFFF_FFFC);
        check_log("p7_req2", 2, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
